// File: rtl/mem_stage.sv
// MIPS memory-access stage: variable-latency data-memory port with timeout,
// pipeline stall generation and the MEM/WB pipeline register.
//
// state | meaning
// IDLE  | no access outstanding; MEM/WB follows EX/MEM each cycle
// WAIT  | dmem_req held high until dmem_ack or the cycle limit is reached
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] res,
    input  logic        zero,
    input  logic [31:0] write_data_ex,
    input  logic [4:0]  write_register_ex,
    input  logic [2:0]  m_MEM,
    input  logic [1:0]  wb_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic        pc_src,
    output logic [31:0] read_data_wb,
    output logic [31:0] alu_res_wb,
    output logic [4:0]  rd_wb,
    output logic        reg_write_wb,
    output logic        mem_to_reg_wb,
    output logic [31:0] write_data_reg,
    output logic        addr_err,
    output logic        bus_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          mem_op;
    logic          misaligned;

    always_comb begin
        mem_op         = m_MEM[1] | m_MEM[0];
        misaligned     = res[1:0] != 2'b00;
        pc_src         = m_MEM[2] & zero;
        write_data_reg = mem_to_reg_wb ? read_data_wb : alu_res_wb;
        stall_mem      = 1'b0;
        case (state)
            IDLE:    stall_mem = mem_op & ~misaligned;
            WAIT:    stall_mem = ~dmem_ack & (cnt != CNT_LAST);
            default: stall_mem = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            read_data_wb  <= '0;
            alu_res_wb    <= '0;
            rd_wb         <= '0;
            reg_write_wb  <= 1'b0;
            mem_to_reg_wb <= 1'b0;
            addr_err      <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!mem_op) begin
                        alu_res_wb    <= res;
                        rd_wb         <= write_register_ex;
                        reg_write_wb  <= wb_MEM[1];
                        mem_to_reg_wb <= wb_MEM[0];
                    end else begin
                        reg_write_wb  <= 1'b0;
                        mem_to_reg_wb <= 1'b0;
                        if (misaligned) begin
                            addr_err <= 1'b1;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= m_MEM[0];
                            dmem_addr  <= {res[31:2], 2'b00};
                            dmem_wdata <= write_data_ex;
                            cnt        <= '0;
                            state      <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        // Upstream advances on this same edge, so the
                        // instruction is retired here and never re-issued.
                        if (!dmem_we) read_data_wb <= dmem_rdata;
                        alu_res_wb    <= res;
                        rd_wb         <= write_register_ex;
                        reg_write_wb  <= wb_MEM[1];
                        mem_to_reg_wb <= wb_MEM[0];
                        dmem_req      <= 1'b0;
                        state         <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        reg_write_wb  <= 1'b0;
                        mem_to_reg_wb <= 1'b0;
                        bus_err       <= 1'b1;
                        dmem_req      <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        reg_write_wb  <= 1'b0;
                        mem_to_reg_wb <= 1'b0;
                        cnt           <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
